cp0_exc_ctrl: RTL and testbench

- CP0 exception controller for the MIPS core. It is the initiator side of the BadVAddr capture interface: it decides when a faulting address is written and what value is written.
- It owns BadVAddr, Count, Compare, Status, Cause and EPC.
- It sequences exception entry and ERET, services MTC0 writes and MFC0 reads, and drives pipeline flush and redirect.
- It sits beside the MEM stage, where exceptions are committed.

---
 rtl/cp0_pkg.sv | 52 +++++
 rtl/cp0_timer.sv | 64 ++++++
 rtl/cp0_exc_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// ---------------------------------------------------------------------------
// cp0_pkg -- constants and types shared by the CP0 exception controller.
//   * CP0 register numbers used by MTC0/MFC0
//   * ExcCode values
//   * Status/Cause bit positions and MTC0 writable-field masks
//   * reset / default values
//   * exception-sequencer state enum
// ---------------------------------------------------------------------------
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status / Cause bit positions
    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int CA_TI  = 30;
    localparam int CA_BD  = 31;

    // Fields software may change through MTC0
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;  // IM[15:8], EXL, IE
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;  // IP[9:8]

    // Defaults
    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } cp0_state_e;

    // Only address-error exceptions carry a meaningful faulting address.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// ---------------------------------------------------------------------------
// cp0_timer -- Count / Compare pair and the timer-interrupt flag (Cause.TI).
//   clk, reset      : clock, synchronous active-high reset
//   count_we        : MTC0 write to Count (wins over the increment)
//   compare_we      : MTC0 write to Compare (also clears TI)
//   wdata           : MTC0 write data
//   count, compare  : current register values
//   ti              : timer interrupt flag, sticky until Compare is written
// Count advances once every two clocks using a free-running toggle bit.
// ---------------------------------------------------------------------------
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        toggle_q,  toggle_d;
    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q,      ti_d;

    always_comb begin
        toggle_d  = ~toggle_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        if (count_we)
            count_d = wdata;
        else if (toggle_q)
            count_d = count_q + 32'd1;   // wraps naturally at 2^32

        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
            ti_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            toggle_q  <= 1'b0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            toggle_q  <= toggle_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl -- CP0 exception controller, sits beside the MEM stage.
// Owns BadVAddr, Count, Compare, Status, Cause and EPC; sequences exception
// entry and ERET, services MTC0/MFC0, and drives pipeline flush/redirect.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   exc_valid       : committed exception (exc_code, exc_pc, exc_in_ds,
//                     exc_badvaddr qualify it)
//   eret            : ERET committed
//   mtc0_we         : MTC0 strobe, cp0_addr / mtc0_wdata qualify it
//   hw_int          : level hardware interrupt lines -> Cause.IP[15:10]
//   mfc0_rdata      : combinational read of register cp0_addr
//   int_pending     : interrupt should be taken (combinational)
//   flush           : one-cycle pipeline flush pulse
//   redirect_pc     : fetch target, valid while flush=1
//
// Build option: define CP0_TIMER_EN to include the Count/Compare timer.
// Without it Count/Compare read 0, ignore writes, and TI is 0.
// ---------------------------------------------------------------------------
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_ds,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [5:0]  hw_int,
    output logic [31:0] mfc0_rdata,
    output logic        int_pending,
    output logic        flush,
    output logic [31:0] redirect_pc
);

    cp0_state_e  state_q,    state_d;
    logic [31:0] redirect_q, redirect_d;
    logic [31:0] status_q,   status_d;
    logic [31:0] epc_q,      epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        bd_q,       bd_d;
    logic [4:0]  exccode_q,  exccode_d;
    logic [1:0]  ip_sw_q,    ip_sw_d;
    logic [5:0]  ip_hw_q,    ip_hw_d;

    // An MTC0 that survives arbitration (IDLE, no exception, no ERET).
    logic        mtc0_go;

    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic        ti;
    logic [31:0] cause_val;

`ifdef CP0_TIMER_EN
    logic count_we;
    logic compare_we;

    assign count_we   = mtc0_go && (cp0_addr == CP0_COUNT);
    assign compare_we = mtc0_go && (cp0_addr == CP0_COMPARE);

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (mtc0_wdata),
        .count      (count_val),
        .compare    (compare_val),
        .ti         (ti)
    );
`else
    assign count_val   = 32'd0;
    assign compare_val = 32'd0;
    assign ti          = 1'b0;
`endif

    // Cause is assembled from its pieces; IP7 also carries the timer flag.
    assign cause_val = {bd_q, ti, 14'd0,
                        ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q,
                        1'b0, exccode_q, 2'b00};

    always_comb begin
        state_d    = state_q;
        redirect_d = redirect_q;
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;
        ip_hw_d    = hw_int;        // sampled every cycle
        mtc0_go    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (exc_valid) begin
                    state_d    = ST_FLUSH;
                    redirect_d = EXC_VECTOR;
                    exccode_d  = exc_code;
                    // Nested exceptions keep the original return point.
                    if (!status_q[ST_EXL]) begin
                        epc_d = exc_in_ds ? (exc_pc - 32'd4) : exc_pc;
                        bd_d  = exc_in_ds;
                    end
                    status_d[ST_EXL] = 1'b1;
                    if (is_addr_exc(exc_code))
                        badvaddr_d = exc_badvaddr;
                end else if (eret) begin
                    state_d          = ST_FLUSH;
                    redirect_d       = epc_q;
                    status_d[ST_EXL] = 1'b0;
                end else if (mtc0_we) begin
                    mtc0_go = 1'b1;
                    case (cp0_addr)
                        CP0_STATUS: status_d = (status_q & ~STATUS_WMASK) |
                                               (mtc0_wdata & STATUS_WMASK);
                        CP0_CAUSE:  ip_sw_d  = mtc0_wdata[9:8];
                        CP0_EPC:    epc_d    = mtc0_wdata;
                        default:    ;       // BadVAddr read-only; timer regs in cp0_timer
                    endcase
                end
            end
            ST_FLUSH: state_d = ST_IDLE;    // requests in this cycle are dropped
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            redirect_q <= 32'd0;
            status_q   <= STATUS_RST;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            bd_q       <= 1'b0;
            exccode_q  <= 5'd0;
            ip_sw_q    <= 2'd0;
            ip_hw_q    <= 6'd0;
        end else begin
            state_q    <= state_d;
            redirect_q <= redirect_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
        end
    end

    // Reads come straight from the registers, so a same-cycle write is not seen.
    always_comb begin
        mfc0_rdata = 32'd0;
        case (cp0_addr)
            CP0_BADVADDR: mfc0_rdata = badvaddr_q;
            CP0_COUNT:    mfc0_rdata = count_val;
            CP0_COMPARE:  mfc0_rdata = compare_val;
            CP0_STATUS:   mfc0_rdata = status_q;
            CP0_CAUSE:    mfc0_rdata = cause_val;
            CP0_EPC:      mfc0_rdata = epc_q;
            default:      mfc0_rdata = 32'd0;
        endcase
    end

    assign int_pending = status_q[ST_IE] & ~status_q[ST_EXL] &
                         (|(cause_val[15:8] & status_q[15:8]));
    assign flush       = (state_q == ST_FLUSH);
    assign redirect_pc = redirect_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp0_exc_ctrl -- directed self-checking bench for cp0_exc_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// Timer checks are compiled in when CP0_TIMER_EN is defined.
// ---------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_ds;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] mtc0_wdata;
    logic [5:0]  hw_int;
    logic [31:0] mfc0_rdata;
    logic        int_pending;
    logic        flush;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code),
        .exc_pc       (exc_pc),
        .exc_in_ds    (exc_in_ds),
        .exc_badvaddr (exc_badvaddr),
        .eret         (eret),
        .mtc0_we      (mtc0_we),
        .cp0_addr     (cp0_addr),
        .mtc0_wdata   (mtc0_wdata),
        .hw_int       (hw_int),
        .mfc0_rdata   (mfc0_rdata),
        .int_pending  (int_pending),
        .flush        (flush),
        .redirect_pc  (redirect_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        cp0_addr = addr;
        #1;
        chk(tag, mfc0_rdata, exp);
    endtask

    task automatic do_exc(input logic [4:0] code, input logic [31:0] pc,
                          input logic ds, input logic [31:0] bad);
        exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_in_ds = ds; exc_badvaddr = bad;
        tick();
        exc_valid = 1'b0; exc_in_ds = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic do_mtc0(input logic [4:0] addr, input logic [31:0] data);
        mtc0_we = 1'b1; cp0_addr = addr; mtc0_wdata = data;
        tick();
        mtc0_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0;
        exc_in_ds = 1'b0; exc_badvaddr = 32'd0; eret = 1'b0; mtc0_we = 1'b0;
        cp0_addr = 5'd0; mtc0_wdata = 32'd0; hw_int = 6'd0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        rd("rst_badvaddr", 5'd8,  32'h0);
        rd("rst_count",    5'd9,  32'h0);
        rd("rst_compare",  5'd11, 32'h0);
        rd("rst_status",   5'd12, 32'h0040_0000);
        rd("rst_cause",    5'd13, 32'h0);
        rd("rst_epc",      5'd14, 32'h0);
        rd("rst_unmapped", 5'd20, 32'h0);
        chk("rst_flush",    flush, 0);
        chk("rst_redirect", redirect_pc, 32'h0);
        chk("rst_intpend",  int_pending, 0);

        // AdEL: BadVAddr captured, vector redirect
        do_exc(5'd4, 32'h8000_0100, 1'b0, 32'h0000_0003);
        chk("adel_flush",    flush, 1);
        chk("adel_redirect", redirect_pc, 32'hBFC0_0380);
        rd("adel_badvaddr", 5'd8,  32'h0000_0003);
        rd("adel_epc",      5'd14, 32'h8000_0100);
        rd("adel_cause",    5'd13, 32'h0000_0010);
        rd("adel_status",   5'd12, 32'h0040_0002);
        tick();
        chk("adel_flush_end", flush, 0);

        // ERET back to 8000_0100
        do_eret();
        chk("eret1_flush",    flush, 1);
        chk("eret1_redirect", redirect_pc, 32'h8000_0100);
        rd("eret1_status",   5'd12, 32'h0040_0000);
        tick();

        // Syscall in delay slot with EXL=0
        do_exc(5'd8, 32'h8000_0204, 1'b1, 32'h0000_DEAD);
        rd("ds_epc",      5'd14, 32'h8000_0200);
        rd("ds_cause",    5'd13, 32'h8000_0020);
        rd("ds_badvaddr", 5'd8,  32'h0000_0003);
        tick();

        // Nested exception with EXL=1 keeps EPC and BD
        do_exc(5'd12, 32'h8000_0300, 1'b0, 32'h0);
        rd("nest_epc",   5'd14, 32'h8000_0200);
        rd("nest_cause", 5'd13, 32'h8000_0030);
        tick();

        // ERET to 8000_0200
        do_eret();
        chk("eret2_flush",    flush, 1);
        chk("eret2_redirect", redirect_pc, 32'h8000_0200);
        rd("eret2_status",   5'd12, 32'h0040_0000);
        tick();

        // exc + eret + mtc0 in one cycle: exception wins
        exc_valid = 1'b1; exc_code = 5'd9; exc_pc = 32'h8000_0400; exc_badvaddr = 32'h0;
        eret = 1'b1; mtc0_we = 1'b1; cp0_addr = 5'd14; mtc0_wdata = 32'h1234_5678;
        tick();
        exc_valid = 1'b0; eret = 1'b0; mtc0_we = 1'b0;
        chk("prio_redirect", redirect_pc, 32'hBFC0_0380);
        rd("prio_epc",    5'd14, 32'h8000_0400);
        rd("prio_status", 5'd12, 32'h0040_0002);

        // Requests during FLUSH are ignored
        eret = 1'b1; mtc0_we = 1'b1; cp0_addr = 5'd14; mtc0_wdata = 32'h1111_1111;
        tick();
        eret = 1'b0; mtc0_we = 1'b0;
        chk("fl_ign_flush", flush, 0);
        rd("fl_ign_status", 5'd12, 32'h0040_0002);
        rd("fl_ign_epc",    5'd14, 32'h8000_0400);

        // BadVAddr is read-only
        do_mtc0(5'd8, 32'hFFFF_FFFF);
        rd("bva_ro", 5'd8, 32'h0000_0003);

        // Read during write returns old value
        mtc0_we = 1'b1; cp0_addr = 5'd14; mtc0_wdata = 32'hCAFE_F00D;
        #1;
        chk("rdw_old", mfc0_rdata, 32'h8000_0400);
        tick();
        mtc0_we = 1'b0;
        rd("rdw_new", 5'd14, 32'hCAFE_F00D);

        // Status write mask and interrupt gating
        do_mtc0(5'd12, 32'hFFFF_FFFF);
        rd("st_mask", 5'd12, 32'h0040_FF03);
        chk("ip_exl_block", int_pending, 0);
        do_mtc0(5'd12, 32'hFFFF_FFFD);
        rd("st_noexl", 5'd12, 32'h0040_FF01);
        hw_int = 6'b000001;
        tick();
        chk("hw_int_pend", int_pending, 1);
        rd("hw_cause", 5'd13, 32'h0000_0424);
        do_mtc0(5'd12, 32'h0000_FF00);
        chk("ie_clear", int_pending, 0);
        hw_int = 6'd0;
        tick();

        // Cause software IP bits
        do_mtc0(5'd13, 32'hFFFF_FFFF);
        rd("ca_mask", 5'd13, 32'h0000_0324);
        do_mtc0(5'd12, 32'h0000_0101);
        chk("sw_int_pend", int_pending, 1);
        do_mtc0(5'd13, 32'h0000_0000);
        chk("sw_int_clr", int_pending, 0);

        // EPC = pc-4 wraps at zero; AdES captures BadVAddr
        do_exc(5'd10, 32'h0000_0000, 1'b1, 32'h0000_0055);
        rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        rd("ri_bva",   5'd8,  32'h0000_0003);
        tick();
        do_exc(5'd5, 32'h8000_0500, 1'b0, 32'h0000_0077);
        rd("ades_bva", 5'd8,  32'h0000_0077);
        rd("ades_epc", 5'd14, 32'hFFFF_FFFC);
        tick();

`ifdef CP0_TIMER_EN
        begin
            int lat;
            lat = 0;
            do_mtc0(5'd12, 32'h0000_8001);
            rd("tm_status", 5'd12, 32'h0040_8001);
            do_mtc0(5'd9, 32'h0000_0005);
            rd("tm_cnt_wr", 5'd9, 32'h0000_0005);
            do_mtc0(5'd11, 32'd10);
            rd("tm_compare", 5'd11, 32'd10);
            do_mtc0(5'd9, 32'd0);
            cp0_addr = 5'd13;
            for (int i = 1; i <= 40; i++) begin
                tick();
                if (mfc0_rdata[30]) begin
                    lat = i;
                    break;
                end
            end
            chk("tm_ti_lat", ((lat >= 19) && (lat <= 22)) ? 32'd1 : 32'd0, 32'd1);
            chk("tm_int_pend", int_pending, 1);
            tick(); tick(); tick();
            cp0_addr = 5'd13; #1;
            chk("tm_ti_sticky", mfc0_rdata[30], 1);
            do_mtc0(5'd11, 32'h0000_0100);
            cp0_addr = 5'd13; #1;
            chk("tm_ti_clr", mfc0_rdata[30], 0);
            chk("tm_int_clr", int_pending, 0);
        end
`else
        do_mtc0(5'd9, 32'h0000_0055);
        rd("nt_count", 5'd9, 32'h0);
        do_mtc0(5'd11, 32'h0000_0003);
        rd("nt_compare", 5'd11, 32'h0);
        cp0_addr = 5'd13; #1;
        chk("nt_ti", mfc0_rdata[30], 0);
`endif

        // Reset while flushing
        do_exc(5'd8, 32'h8000_0600, 1'b0, 32'h0);
        chk("rf_flush_on", flush, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rf_flush",    flush, 0);
        chk("rf_redirect", redirect_pc, 32'h0);
        rd("rf_status",   5'd12, 32'h0040_0000);
        rd("rf_epc",      5'd14, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
